// File: rtl/fpu_pkg.sv
// fpu_pkg: shared fp32 field layout, internal widths and operand unpacking for the FPU datapaths.
package fpu_pkg;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;
    // Signed working exponent wide enough for ea+eb-BIAS plus normalise/round carries.
    localparam int EI_W     = 10;
    localparam int PROD_W   = 2 * (MAN_W + 1);

    typedef struct packed {
        logic             sign;
        logic [EI_W-1:0]  exp;
        logic [MAN_W:0]   ma;
        logic [MAN_W:0]   mb;
        logic             zero;
        logic             inf;
    } unpack_t;

    typedef struct packed {
        logic              sign;
        logic [EI_W-1:0]   exp;
        logic [PROD_W-1:0] prod;
        logic              zero;
        logic              inf;
    } prod_t;

    function automatic unpack_t fp_unpack_mul(input logic [31:0] x, input logic [31:0] y);
        unpack_t u;
        logic [EXP_W-1:0] ex;
        logic [EXP_W-1:0] ey;
        ex     = x[EXP_MSB:EXP_LSB];
        ey     = y[EXP_MSB:EXP_LSB];
        u.sign = x[SIGN_BIT] ^ y[SIGN_BIT];
        u.exp  = EI_W'(ex) + EI_W'(ey) - EI_W'(BIAS);
        u.ma   = {1'b1, x[MAN_MSB:0]};
        u.mb   = {1'b1, y[MAN_MSB:0]};
        // Denormals flush to zero; NaN is folded into inf.
        u.zero = (ex == '0) | (ey == '0);
        u.inf  = (&ex) | (&ey);
        return u;
    endfunction
endpackage

// File: rtl/fp_round_ne.sv
// fp_round_ne: normalise a 48-bit mantissa product, round to nearest-even and pack fp32 with saturation/flush.
module fp_round_ne
    import fpu_pkg::*;
(
    input  logic              sign_i,
    input  logic [EI_W-1:0]   exp_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              zero_i,
    input  logic              inf_i,
    output logic [31:0]       d_o,
    output logic              overflow_o,
    output logic              underflow_o
);
    localparam logic signed [EI_W-1:0] E_TOP  = EI_W'(EXP_MAX);
    localparam logic signed [EI_W-1:0] E_ZERO = '0;

    logic                   hi, g, s, inc, c, ovf, unf;
    logic [MAN_W-1:0]       mant, mant_r;
    logic signed [EI_W-1:0] e_r;

    assign hi   = prod_i[47];
    assign mant = hi ? prod_i[46:24] : prod_i[45:23];
    assign g    = hi ? prod_i[23] : prod_i[22];
    assign s    = hi ? |prod_i[22:0] : |prod_i[21:0];
    assign inc  = g & (s | mant[0]);
    // A carry out of the mantissa leaves mant_r at zero, which is exactly 1.0 at the next exponent.
    assign {c, mant_r} = {1'b0, mant} + (MAN_W + 1)'(inc);
    assign e_r  = $signed(exp_i) + $signed({9'b0, hi}) + $signed({9'b0, c});
    assign ovf  = inf_i | (e_r >= E_TOP);
    assign unf  = e_r <= E_ZERO;

    assign overflow_o  = ~zero_i & ovf;
    assign underflow_o = ~zero_i & ~ovf & unf;
    assign d_o = (zero_i | underflow_o) ? {sign_i, 31'b0} :
                 overflow_o             ? {sign_i, 8'hFF, 23'b0} :
                                          {sign_i, e_r[7:0], mant_r};
endmodule

// File: rtl/fdiv_stage.sv
// fdiv_stage: 3-stage a*(1/b) back half of the divider (unpack, multiply, round) with valid/ready on both sides.
module fdiv_stage
    import fpu_pkg::*;
#(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      inv_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      d,
    output logic [TAG_W-1:0] out_tag,
    output logic             overflow,
    output logic             underflow
);
    unpack_t          s1_q, s1_d;
    prod_t            s2_q, s2_d;
    logic             v1_q, v2_q, vo_q, adv;
    logic [TAG_W-1:0] t1_q, t2_q, to_q;
    logic [31:0]      d_q, d_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;

    // The whole pipe moves in lockstep, so a free output slot is the only condition to advance.
    assign adv      = ~vo_q | out_ready;
    assign in_ready = adv;

    assign s1_d = fp_unpack_mul(a, inv_b);
    assign s2_d = '{sign: s1_q.sign, exp: s1_q.exp, prod: PROD_W'(s1_q.ma) * PROD_W'(s1_q.mb),
                    zero: s1_q.zero, inf: s1_q.inf};

    fp_round_ne u_round (
        .sign_i      (s2_q.sign),
        .exp_i       (s2_q.exp),
        .prod_i      (s2_q.prod),
        .zero_i      (s2_q.zero),
        .inf_i       (s2_q.inf),
        .d_o         (d_d),
        .overflow_o  (ovf_d),
        .underflow_o (unf_d)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            vo_q  <= 1'b0;
            s1_q  <= '0;
            s2_q  <= '0;
            t1_q  <= '0;
            t2_q  <= '0;
            to_q  <= '0;
            d_q   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (adv) begin
            v1_q  <= in_valid;
            s1_q  <= s1_d;
            t1_q  <= in_tag;
            v2_q  <= v1_q;
            s2_q  <= s2_d;
            t2_q  <= t1_q;
            vo_q  <= v2_q;
            d_q   <= d_d;
            to_q  <= t2_q;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out_valid = vo_q;
    assign d         = d_q;
    assign out_tag   = to_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
endmodule

// File: tb/tb_fdiv_stage.sv
// tb_fdiv_stage: directed and randomized checks of fdiv_stage against an exact-integer RNE/FTZ product model.
module tb_fdiv_stage;
    localparam int TAG_W = 6;

    logic             clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0]      a = '0, inv_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready, out_valid, overflow, underflow;
    logic [31:0]      d;
    logic [TAG_W-1:0] out_tag;

    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0]      d;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             unf;
    } res_t;

    res_t             exp_q[$];
    logic [TAG_W-1:0] got_tags[$];
    res_t             got_e;
    logic             hold = 1'b0;
    logic [31:0]      pd;
    logic [TAG_W-1:0] pt;
    logic             rnd_done;

    always #5 clk = ~clk;

    fdiv_stage #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .inv_b     (inv_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .out_tag   (out_tag),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Exact product as an integer, rounded to 24 significant bits by remainder comparison.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
        res_t r;
        int ex, ey, msb, sh, e;
        logic [47:0] p, q, rem, half;
        logic s;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s = x[31] ^ y[31];
        r.tag = t;
        r.ovf = 1'b0;
        r.unf = 1'b0;
        r.d = {s, 31'b0};
        if (ex == 0 || ey == 0) return r;
        if (ex == 255 || ey == 255) begin
            r.d = {s, 8'hFF, 23'b0};
            r.ovf = 1'b1;
            return r;
        end
        p = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
        msb = 0;
        for (int k = 47; k >= 0; k--) if (p[k]) begin msb = k; break; end
        sh = msb - 23;
        q = p >> sh;
        rem = p - (q << sh);
        half = 48'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 48'd1;
        e = ex + ey - 127 + (msb - 46);
        if (q[24]) begin q = q >> 1; e++; end
        if (e >= 255) begin r.d = {s, 8'hFF, 23'b0}; r.ovf = 1'b1; end
        else if (e <= 0) r.unf = 1'b1;
        else r.d = {s, e[7:0], q[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        int r;
        r = $urandom_range(0, 9);
        e = r == 0 ? 8'd0 : r == 1 ? 8'd255 :
            r <= 3 ? 8'($urandom_range(1, 10)) :
            r <= 5 ? 8'($urandom_range(245, 254)) : 8'($urandom_range(64, 190));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            hold = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_d", d, pd);
                chk("hold_tag", out_tag, pt);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: got d=%h tag=%0d, nothing expected", d, out_tag);
                end else begin
                    got_e = exp_q.pop_front();
                    chk("d", d, got_e.d);
                    chk("tag", out_tag, got_e.tag);
                    chk("overflow", overflow, got_e.ovf);
                    chk("underflow", underflow, got_e.unf);
                    got_tags.push_back(out_tag);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, inv_b, in_tag));
            hold = out_valid && !out_ready;
            pd = d;
            pt = out_tag;
        end
    end

    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] t);
        int n = 0;
        a = x;
        inv_b = y;
        in_tag = t;
        in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!in_ready && n < 200);
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(posedge clk); #1; n++; end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic run_one(input logic [31:0] x, input logic [31:0] y, input logic [31:0] rd,
                           input logic ro, input logic ru, input logic [TAG_W-1:0] t);
        int n = 0;
        res_t m;
        m = model(x, y, t);
        chk("model_pin", {m.d, m.ovf, m.unf}, {rd, ro, ru});
        out_ready = 1'b1;
        a = x;
        inv_b = y;
        in_tag = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 10);
        chk("latency", n, 3);
        chk("d_lit", d, rd);
        chk("tag_lit", out_tag, t);
        chk("ovf_lit", overflow, ro);
        chk("unf_lit", underflow, ru);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] da[13], db[13], dd[13];
        logic        dov[13], dun[13];
        da  = '{32'h40400000, 32'h3F800001, 32'h3FFFFFFF, 32'h7F000000, 32'h00800000, 32'h00000000, 32'hC0400000,
                32'h3F800001, 32'h3F800003, 32'h3F918E00, 32'h7F800000, 32'h00000000, 32'h80800000};
        db  = '{32'h3F000000, 32'h3F800001, 32'h40000000, 32'h40800000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
                32'h3FC00000, 32'h3FC00000, 32'h3FE12000, 32'h3F800000, 32'h7F800000, 32'h3F000000};
        dd  = '{32'h3FC00000, 32'h3F800002, 32'h407FFFFF, 32'h7F800000, 32'h00000000, 32'h00000000, 32'hBFC00000,
                32'h3FC00002, 32'h3FC00004, 32'h40000000, 32'h7F800000, 32'h00000000, 32'h80000000};
        dov = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        dun = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};

        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_d", d, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #2 rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_one(da[i], db[i], dd[i], dov[i], dun[i], 6'(i + 10));
        drain();

        got_tags.delete();
        fork
            for (int i = 0; i < 6; i++) send(rnd_fp(), rnd_fp(), 6'(i));
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("stall_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                @(posedge clk); #1;
                repeat (1) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("order_count", got_tags.size(), 6);
        for (int i = 0; i < 6 && i < got_tags.size(); i++) chk("order", got_tags[i], i);

        out_ready = 1'b0;
        send(32'h40400000, 32'h3F000000, 6'd1);
        send(32'h3F800001, 32'h3F800001, 6'd2);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("pre_reset_valid", out_valid, 1);
        @(posedge clk); #2 rstn = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_d", d, 0);
        chk("async_rst_tag", out_tag, 0);
        @(negedge clk);
        @(posedge clk); #2 rstn = 1'b1;
        out_ready = 1'b1;
        repeat (6) begin @(negedge clk); chk("post_reset_valid", out_valid, 0); end
        @(posedge clk); #1;
        send(32'h3FFFFFFF, 32'h40000000, 6'd3);
        drain();

        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send(rnd_fp(), rnd_fp(), 6'(i));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
